// File: rtl/pixel_readout_scheduler.sv
// Pixel readout scheduler: scans a ROWS x COLS frequency-output pixel array in
// row-major order, settles, gates rising edges of the selected pixel over a
// fixed window and delivers each count with its address over valid/ready.
// Ports:
//   CLK, RST (async active-high)   clock / reset
//   START, CONTINUOUS, ABORT       scan control
//   PIXEL_FREQ                     asynchronous pixel frequency input
//   ROW_SEL, COL_SEL               array select lines
//   DATA_OUT/ROW/COL, DATA_VALID   measurement result, DATA_READY handshake
//   BUSY, FRAME_DONE               status
module pixel_readout_scheduler #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned COUNT_BITS    = 16,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  CONTINUOUS,
  input  logic                  ABORT,
  input  logic                  PIXEL_FREQ,
  output logic [RW-1:0]         ROW_SEL,
  output logic [CW-1:0]         COL_SEL,
  output logic [COUNT_BITS-1:0] DATA_OUT,
  output logic [RW-1:0]         DATA_ROW,
  output logic [CW-1:0]         DATA_COL,
  output logic                  DATA_VALID,
  input  logic                  DATA_READY,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  localparam int unsigned TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, PRESENT} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [COUNT_BITS-1:0] data_q, data_d;
  logic [RW-1:0]         drow_q, drow_d;
  logic [CW-1:0]         dcol_q, dcol_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  fd_q, fd_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic                  rise_c;
  logic                  last_pix_c;

  // Two-flop synchroniser plus previous-value register for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= PIXEL_FREQ;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_c     = sync2_q & ~prev_q;
  assign last_pix_c = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      drow_q  <= '0;
      dcol_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      drow_q  <= drow_d;
      dcol_q  <= dcol_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    drow_d  = drow_q;
    dcol_d  = dcol_q;
    fd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          state_d = SETTLE;
          timer_d = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      SETTLE: begin
        if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
          state_d = GATE;
          timer_d = '0;
          count_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GATE: begin
        // Saturating count; the final gate cycle's edge is included in the result
        if (rise_c && (count_q != {COUNT_BITS{1'b1}})) begin
          count_d = count_q + COUNT_BITS'(1);
        end
        if (timer_q == TW'(GATE_CYCLES - 1)) begin
          state_d = PRESENT;
          timer_d = '0;
          data_d  = count_d;
          drow_d  = row_q;
          dcol_d  = col_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PRESENT: begin
        if (DATA_READY) begin
          timer_d = '0;
          if (last_pix_c) begin
            row_d   = '0;
            col_d   = '0;
            fd_d    = 1'b1;
            state_d = CONTINUOUS ? SETTLE : IDLE;
          end else begin
            state_d = SETTLE;
            if (col_q == CW'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle handshake
    if (ABORT && (state_q != IDLE)) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      fd_d    = 1'b0;
    end

    valid_d = (state_d == PRESENT);
    busy_d  = (state_d != IDLE);
  end

  assign ROW_SEL    = row_q;
  assign COL_SEL    = col_q;
  assign DATA_OUT   = data_q;
  assign DATA_ROW   = drow_q;
  assign DATA_COL   = dcol_q;
  assign DATA_VALID = valid_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: doc/pixel_readout_scheduler.md
Name: pixel_readout_scheduler

Overview:
Sequences readout of a ROWS x COLS array of frequency-output pixels. It drives the row/column select lines shared by the array, waits for the selected pixel's output to settle, then counts its rising edges over a fixed gate window. Each count is delivered with its pixel address over a valid/ready handshake. It sits between the pixel array's shared frequency output line and the downstream readout/serialiser logic.

Parameters:
ROWS, 4, number of pixel rows (>=1)
COLS, 4, number of pixel columns (>=1)
SETTLE_CYCLES, 4, CLK cycles to wait after changing select before gating (>=3, covers the synchroniser)
GATE_CYCLES, 1024, CLK cycles in the edge-counting window (>=1)
COUNT_BITS, 16, width of the edge count

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high; all state and outputs cleared while high
START  in  1  one-cycle pulse; begins a frame scan when idle
CONTINUOUS  in  1  when 1, a new frame starts automatically after the last pixel
ABORT  in  1  synchronous abort; returns to idle
PIXEL_FREQ  in  1  selected pixel frequency output, asynchronous to CLK
ROW_SEL  out  RW=max(1,$clog2(ROWS))  row select to array
COL_SEL  out  CW=max(1,$clog2(COLS))  column select to array
DATA_OUT  out  COUNT_BITS  measured edge count
DATA_ROW  out  RW  row of DATA_OUT
DATA_COL  out  CW  column of DATA_OUT
DATA_VALID  out  1  DATA_* valid
DATA_READY  in  1  downstream accepts when DATA_VALID high
BUSY  out  1  high in any state except IDLE
FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset values: ROW_SEL=0, COL_SEL=0, DATA_OUT=0, DATA_ROW=0, DATA_COL=0, DATA_VALID=0, BUSY=0, FRAME_DONE=0; state IDLE; synchroniser flops 0.
- PIXEL_FREQ passes through a 2-flop synchroniser plus an edge register. A rising edge is sync2=1 while the previous value was 0.
- States: IDLE, SETTLE, GATE, PRESENT.
- IDLE: START=1 -> SETTLE next cycle with ROW_SEL=COL_SEL=0 and BUSY=1. START is ignored in all other states.
- SETTLE: a counter runs SETTLE_CYCLES cycles, then the block enters GATE. The edge counter is cleared to 0 on GATE entry. Edges seen during SETTLE are ignored.
- GATE: lasts exactly GATE_CYCLES cycles. Each cycle with a detected rising edge increments the count. The count saturates at 2^COUNT_BITS-1 and does not wrap. On the last gate cycle, including an edge detected that cycle, the block moves to PRESENT.
- PRESENT: DATA_VALID=1. DATA_OUT, DATA_ROW and DATA_COL hold the final count and the current select. All DATA_* outputs stay stable until DATA_VALID & DATA_READY.
- On handshake, the select advances row-major: COL_SEL+1. At COLS-1, COL_SEL wraps to 0 and ROW_SEL+1. DATA_VALID drops the next cycle.
  - Not the last pixel -> SETTLE.
  - Last pixel (ROWS-1, COLS-1): FRAME_DONE=1 for one cycle and ROW_SEL=COL_SEL=0. Then SETTLE if CONTINUOUS=1 (sampled on the handshake cycle), else IDLE with BUSY=0.
- Select lines change only on handshake or on START. They are otherwise constant, including across the gate window.
- ABORT=1 in any non-IDLE state -> IDLE next cycle, with DATA_VALID=0, selects=0 and no FRAME_DONE. ABORT takes priority over a simultaneous handshake; that pixel counts as not delivered. ABORT in IDLE has no effect. ABORT and START in the same cycle in IDLE: the block stays IDLE.
- RST asserted mid-operation: all outputs return to reset values immediately and asynchronously. After RST release the block waits in IDLE for START.
- Latency per pixel with DATA_READY held high: SETTLE_CYCLES + GATE_CYCLES + 1 cycles from select change to handshake.

Test Plan:
- Reset check: RST during GATE -> all outputs 0 at once. After release, BUSY=0 until START.
- Count accuracy (ROWS=COLS=2, SETTLE=4, GATE=64): PIXEL_FREQ toggles every 4 CLK (period 8) -> DATA_OUT in {7,8,9}. A constant 0 input -> DATA_OUT=0.
- Scan order: single frame with DATA_READY=1 -> DATA_ROW/DATA_COL sequence (0,0),(0,1),(1,0),(1,1). FRAME_DONE is exactly one pulse after the 4th handshake, then BUSY=0.
- Backpressure: DATA_READY=0 for 20 cycles in PRESENT -> DATA_VALID and DATA_* held stable and selects unchanged. Raising READY -> one transfer, then SETTLE begins.
- Saturation: COUNT_BITS=4, GATE=64, input period 2 CLK -> DATA_OUT=15.
- Continuous/abort: CONTINUOUS=1 -> second frame starts at (0,0) without START. ABORT together with a handshake on pixel (0,1) -> IDLE, no FRAME_DONE, next START restarts at (0,0).
